// File: rtl/ifetch_unit_if.sv
// Fetch-unit bundle: redirect input, CPU-side instruction port and the decode-side buffer head.
// master = fetch unit, slave = memory bridge / decode / redirect source.
interface ifetch_unit_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_adel;

   modport master (
      input  redirect_valid, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, out_ready,
      output inst_req, inst_addr, out_valid, out_pc, out_inst, out_adel
   );

   modport slave (
      output redirect_valid, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, out_ready,
      input  inst_req, inst_addr, out_valid, out_pc, out_inst, out_adel
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues PC requests, tags responses and buffers them for decode.
// Latency: data_ok -> out_valid one cycle; requests are credit-limited so responses never stall.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC        = 32'hbfc00000,
   parameter int          MAX_OUTSTANDING = 2,
   parameter int          FIFO_DEPTH      = 4
) (
   input  logic          clk,
   input  logic          reset,
   ifetch_unit_if.master bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int TQ = 2 ** CW;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } entry_t;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] stale_q, stale_d;
   logic          halted_q, halted_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [31:0]   tag_q [TQ];
   logic [31:0]   tag_d [TQ];
   entry_t        fifo_q [FIFO_DEPTH];

   logic [CW-1:0] live;
   logic [CW-1:0] tag_wr_idx;
   logic          aligned;
   logic          credit_ok;
   logic          req;
   logic          accept;
   logic          adel_push;
   logic          resp_keep;
   logic          push_en;
   logic          pop;
   entry_t        push_entry;
   entry_t        head;

   // Live requests are those not orphaned by a redirect; each one owns a reserved FIFO slot.
   assign live      = outst_q - stale_q;
   assign aligned   = (fetch_pc_q[1:0] == 2'b00);
   assign credit_ok = (8'(cnt_q) + 8'(live)) < 8'(FIFO_DEPTH);

   assign req       = !reset && !bus.redirect_valid && !halted_q && aligned
                      && (outst_q < CW'(MAX_OUTSTANDING)) && credit_ok;
   assign accept    = req && bus.inst_addr_ok;
   assign adel_push = !reset && !bus.redirect_valid && !halted_q && !aligned
                      && credit_ok && (live == '0);
   assign resp_keep = bus.inst_data_ok && !bus.redirect_valid && (stale_q == '0);
   assign pop       = (cnt_q != '0) && bus.out_ready && !bus.redirect_valid;
   assign push_en   = resp_keep || adel_push;

   assign tag_wr_idx = live - CW'(resp_keep);

   always_comb begin
      push_entry = '0;
      if (resp_keep) begin
         push_entry.pc   = tag_q[0];
         push_entry.inst = bus.inst_rdata;
      end else begin
         push_entry.pc   = fetch_pc_q;
         push_entry.adel = 1'b1;
      end
   end

   always_comb begin
      tag_d = tag_q;
      if (resp_keep) begin
         for (int i = 0; i < TQ - 1; i++) begin
            tag_d[i] = tag_q[i + 1];
         end
      end
      if (accept) begin
         tag_d[tag_wr_idx] = fetch_pc_q;
      end
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      halted_d   = halted_q;
      outst_d    = outst_q + CW'(accept) - CW'(bus.inst_data_ok);
      stale_d    = stale_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      cnt_d      = cnt_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = bus.redirect_pc;
         halted_d   = 1'b0;
         // Everything still in flight, minus the response arriving now, becomes garbage.
         stale_d    = outst_q - CW'(bus.inst_data_ok);
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         cnt_d      = '0;
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (adel_push) begin
            halted_d = 1'b1;
         end
         if (bus.inst_data_ok && (stale_q != '0)) begin
            stale_d = stale_q - 1'b1;
         end
         if (push_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         cnt_d = cnt_q + (AW+1)'(push_en) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         halted_q   <= 1'b0;
         outst_q    <= '0;
         stale_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         halted_q   <= halted_d;
         outst_q    <= outst_d;
         stale_q    <= stale_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the counters above.
   always_ff @(posedge clk) begin
      tag_q <= tag_d;
      if (push_en) begin
         fifo_q[wr_ptr_q] <= push_entry;
      end
   end

   assign head          = fifo_q[rd_ptr_q];
   assign bus.inst_req  = req;
   assign bus.inst_addr = fetch_pc_q;
   assign bus.out_valid = (cnt_q != '0);
   assign bus.out_pc    = bus.out_valid ? head.pc   : 32'd0;
   assign bus.out_inst  = bus.out_valid ? head.inst : 32'd0;
   assign bus.out_adel  = bus.out_valid ? head.adel : 1'b0;
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: randomized memory/decode/redirect traffic checked against a queue-based model.
module tb_ifetch_unit;
   localparam logic [31:0] RESET_PC = 32'hbfc00000;
   localparam int MAXO  = 2;
   localparam int DEPTH = 4;

   typedef struct packed { logic [31:0] pc; logic stale; } fly_t;
   typedef struct packed { logic [31:0] pc; logic [31:0] inst; logic adel; } ent_t;
   typedef struct packed { logic [31:0] addr; int due; } mreq_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ifetch_unit_if bus ();

   ifetch_unit #(
      .RESET_PC       (RESET_PC),
      .MAX_OUTSTANDING(MAXO),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // model and environment state
   logic [31:0] m_pc;
   logic        m_halted;
   fly_t        m_fly [$];
   ent_t        m_fifo [$];
   mreq_t       memq [$];

   int lat_min = 1, lat_max = 1, aok_pct = 100, rdy_pct = 100;
   int cyc = 0, total = 0, bad = 0;
   int acc_cnt = 0, first_req_cyc = -1, first_vld_cyc = -1;
   logic [31:0] first_acc_addr;
   ent_t        first_ent;
   logic        last_req;

   function automatic logic [31:0] data_fn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1234_5678;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int live_cnt();
      int n = 0;
      foreach (m_fly[i]) if (!m_fly[i].stale) n++;
      return n;
   endfunction

   task automatic step(input logic rv, input logic [31:0] rpc);
      int    live;
      logic  exp_req, dok, adel_now;
      mreq_t mh;
      fly_t  fh;
      @(negedge clk);
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.out_ready      = ($urandom_range(99) < rdy_pct);
      dok = !reset && (memq.size() > 0) && (memq[0].due <= cyc);
      bus.inst_data_ok   = dok;
      bus.inst_rdata     = dok ? data_fn(memq[0].addr) : $urandom;
      #1;
      bus.inst_addr_ok = bus.inst_req && ($urandom_range(99) < aok_pct);
      #1;
      last_req = bus.inst_req;
      if (reset) begin
         check("req_in_reset", bus.inst_req, 0);
         m_pc = RESET_PC;
         m_halted = 1'b0;
         m_fly.delete();
         m_fifo.delete();
         memq.delete();
      end else begin
         live    = live_cnt();
         exp_req = !rv && !m_halted && (m_pc[1:0] == 2'b00) && (m_fly.size() < MAXO)
                   && (m_fifo.size() + live < DEPTH);
         adel_now = !rv && !m_halted && (m_pc[1:0] != 2'b00)
                    && (m_fifo.size() + live < DEPTH) && (live == 0);
         check("inst_req", bus.inst_req, exp_req);
         check("inst_addr", bus.inst_addr, m_pc);
         check("out_valid", bus.out_valid, m_fifo.size() > 0);
         if (m_fifo.size() > 0) begin
            check("out_pc", bus.out_pc, m_fifo[0].pc);
            check("out_inst", bus.out_inst, m_fifo[0].inst);
            check("out_adel", bus.out_adel, m_fifo[0].adel);
            if (first_vld_cyc < 0) begin
               first_vld_cyc = cyc;
               first_ent     = m_fifo[0];
            end
         end
         // memory side
         if (dok) mh = memq.pop_front();
         if (bus.inst_req && bus.inst_addr_ok) begin
            memq.push_back('{addr: bus.inst_addr, due: cyc + $urandom_range(lat_max, lat_min)});
            acc_cnt++;
            if (first_req_cyc < 0) begin
               first_req_cyc  = cyc;
               first_acc_addr = bus.inst_addr;
            end
         end
         // model update
         if (rv) begin
            if (dok && m_fly.size() > 0) fh = m_fly.pop_front();
            foreach (m_fly[i]) m_fly[i].stale = 1'b1;
            m_fifo.delete();
            m_pc = rpc;
            m_halted = 1'b0;
         end else begin
            if (bus.out_ready && m_fifo.size() > 0) void'(m_fifo.pop_front());
            if (dok && m_fly.size() > 0) begin
               fh = m_fly.pop_front();
               if (!fh.stale) m_fifo.push_back('{pc: fh.pc, inst: data_fn(fh.pc), adel: 1'b0});
            end
            if (adel_now) begin
               m_fifo.push_back('{pc: m_pc, inst: 32'd0, adel: 1'b1});
               m_halted = 1'b1;
            end
            if (exp_req && bus.inst_addr_ok) begin
               m_fly.push_back('{pc: m_pc, stale: 1'b0});
               m_pc = m_pc + 32'd4;
            end
            check("fifo_overflow", m_fifo.size() > DEPTH, 0);
         end
      end
      cyc++;
   endtask

   task automatic reset_checks();
      @(posedge clk);
      #1;
      check("rst_inst_req", bus.inst_req, 0);
      check("rst_inst_addr", bus.inst_addr, RESET_PC);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_pc", bus.out_pc, 0);
      check("rst_out_inst", bus.out_inst, 0);
      check("rst_out_adel", bus.out_adel, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, 32'd0);
      step(1'b0, 32'd0);
      reset = 1'b0;
      acc_cnt = 0;
      first_req_cyc = -1;
      first_vld_cyc = -1;
   endtask

   initial begin
      logic [31:0] rpc;
      int start;
      reset = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      bus.inst_addr_ok   = 1'b0;
      bus.inst_data_ok   = 1'b0;
      bus.inst_rdata     = 32'd0;
      bus.out_ready      = 1'b0;

      // reset values
      step(1'b0, 32'd0);
      step(1'b0, 32'd0);
      reset_checks();
      reset = 1'b0;

      // zero-wait streaming
      start = cyc;
      for (int i = 0; i < 12; i++) step(1'b0, 32'd0);
      check("first_req_cycle", first_req_cyc - start, 0);
      check("first_acc_addr", first_acc_addr, 32'hbfc00000);
      check("req_to_valid", first_vld_cyc - first_req_cyc, 2);
      check("first_head_pc", first_ent.pc, 32'hbfc00000);
      check("first_head_inst", first_ent.inst, 32'ha71d_ae03 ^ 32'h0000_0000 ^ data_fn(32'hbfc00000) ^ 32'ha71d_ae03);
      check("stream_accepts", acc_cnt, 12);

      // decode stalled from the start
      do_reset();
      rdy_pct = 0;
      for (int i = 0; i < 10; i++) step(1'b0, 32'd0);
      check("stall_accepts", acc_cnt, 4);
      check("stall_req_low", last_req, 0);
      rdy_pct = 100;
      for (int i = 0; i < 8; i++) step(1'b0, 32'd0);

      // slow memory, redirect with two in flight
      do_reset();
      lat_min = 3; lat_max = 3;
      step(1'b0, 32'd0);
      step(1'b0, 32'd0);
      step(1'b1, 32'h80000100);
      first_vld_cyc = -1;
      for (int i = 0; i < 10; i++) step(1'b0, 32'd0);
      check("redir_first_pc", first_ent.pc, 32'h80000100);

      // redirect coinciding with a response
      do_reset();
      lat_min = 2; lat_max = 2;
      step(1'b0, 32'd0);
      step(1'b0, 32'd0);
      check("resp_pending", memq.size() > 0 && memq[0].due == cyc, 1);
      step(1'b1, 32'h80000400);
      first_vld_cyc = -1;
      for (int i = 0; i < 8; i++) step(1'b0, 32'd0);
      check("redir_resp_pc", first_ent.pc, 32'h80000400);

      // misaligned redirect halts until the next redirect
      lat_min = 1; lat_max = 1;
      step(1'b1, 32'h80000102);
      first_vld_cyc = -1;
      acc_cnt = 0;
      for (int i = 0; i < 6; i++) step(1'b0, 32'd0);
      check("adel_no_req", acc_cnt, 0);
      check("adel_pc", first_ent.pc, 32'h80000102);
      check("adel_inst", first_ent.inst, 0);
      check("adel_flag", first_ent.adel, 1);
      step(1'b1, 32'h80000200);
      first_vld_cyc = -1;
      for (int i = 0; i < 6; i++) step(1'b0, 32'd0);
      check("resume_pc", first_ent.pc, 32'h80000200);

      // reset in the middle of traffic
      rdy_pct = 0; lat_min = 2; lat_max = 2;
      for (int i = 0; i < 5; i++) step(1'b0, 32'd0);
      reset = 1'b1;
      step(1'b0, 32'd0);
      reset_checks();
      reset = 1'b0;
      acc_cnt = 0; first_req_cyc = -1;
      rdy_pct = 100; lat_min = 1; lat_max = 1;
      for (int i = 0; i < 4; i++) step(1'b0, 32'd0);
      check("restart_addr", first_acc_addr, 32'hbfc00000);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if (i % 60 == 0) begin
            lat_min = $urandom_range(3, 1);
            lat_max = lat_min + $urandom_range(3);
            aok_pct = $urandom_range(100, 30);
            rdy_pct = $urandom_range(100, 20);
         end
         if ($urandom_range(199) == 0) begin
            reset = 1'b1;
            step(1'b0, 32'd0);
            reset = 1'b0;
         end else if ($urandom_range(99) < 6) begin
            rpc = 32'h8000_0000 | ($urandom_range(1023) << 2);
            if ($urandom_range(9) == 0) rpc[1:0] = 2'($urandom_range(3, 1));
            if ($urandom_range(14) == 0) rpc = 32'hffff_fff8;
            step(1'b1, rpc);
         end else begin
            step(1'b0, 32'd0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
